rcvbuf_stream: RTL and testbench

RCVBUF_STREAM -- requirements
Module: rcvbuf_stream

---
 rtl/rcvbuf_stream.sv | 140 ++++++++++++++
 tb/tb_rcvbuf_stream.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcvbuf_stream.sv
// Receive buffer that collects parallel words into a circular store and,
// once enough words are buffered (or on flush), serialises them one bit per
// bit_tick onto databit. Words arriving while streaming are appended and
// sent back to back; the stream ends only on a word boundary with the
// buffer empty.
module rcvbuf_stream #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 1250,
  parameter int THRESH    = 1250,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                       rcvbuf_clk,
  input  logic                       rst,
  input  logic                       newdata,
  input  logic [DATA_W-1:0]          rbr,
  input  logic                       bit_tick,
  input  logic                       flush,
  output logic                       databit,
  output logic                       streaming,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       overflow,
  output logic                       done
);

  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int BIDX_W = $clog2(DATA_W);

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [BIDX_W-1:0]  bidx;
  logic [DATA_W-1:0]  shreg;
  logic [DATA_W-1:0]  rd_word;
  logic [LVL_W-1:0]   level_wr;
  logic               wr_en, pop, end_stream;

  // Pointers wrap at DEPTH-1, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Full is judged on the pre-pop level, so a write racing a pop on a full
  // buffer is dropped.
  assign full      = (level == LVL_W'(DEPTH));
  assign streaming = (state_q == STREAM);
  assign wr_en     = newdata && !full;
  assign level_wr  = level + LVL_W'(wr_en);
  assign rd_word   = mem[rd_ptr];

  // Next-state logic plus the pop / end-of-stream decisions at word boundaries.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    pop        = 1'b0;
    end_stream = 1'b0;
    case (state_q)
      FILL: begin
        // Threshold uses the post-write count so streaming rises right after
        // the word that reaches it; flush needs at least one stored word.
        if (level_wr >= LVL_W'(THRESH) || (flush && level != '0))
          state_d = STREAM;
      end
      STREAM: begin
        if (bit_tick && bidx == '0) begin
          if (level != '0) begin
            pop = 1'b1;
          end else begin
            end_stream = 1'b1;
            state_d    = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge rcvbuf_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // Word storage.
  always_ff @(posedge rcvbuf_clk) begin
    // NOTE: the array itself is not reset; reset clears the pointers and
    // level, which makes any stale contents unreachable.
    if (wr_en && !rst) mem[wr_ptr] <= rbr;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge rcvbuf_clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en)         wr_ptr   <= ptr_inc(wr_ptr);
      if (pop)           rd_ptr   <= ptr_inc(rd_ptr);
      if (newdata && full) overflow <= 1'b1;
      if (wr_en && !pop)      level <= level + 1'b1;
      else if (!wr_en && pop) level <= level - 1'b1;
    end
  end

  // Serialiser: load a word at bidx 0, shift out one bit per tick after it.
  always_ff @(posedge rcvbuf_clk) begin
    if (rst) begin
      bidx    <= '0;
      shreg   <= '0;
      databit <= IDLE_BIT;
      done    <= 1'b0;
    end else begin
      done <= end_stream;
      if (pop) begin
        databit <= LSB_FIRST ? rd_word[0] : rd_word[DATA_W-1];
        shreg   <= LSB_FIRST ? (rd_word >> 1) : (rd_word << 1);
        bidx    <= BIDX_W'(1);
      end else if (end_stream) begin
        databit <= IDLE_BIT;
      end else if (streaming && bit_tick && bidx != '0) begin
        databit <= LSB_FIRST ? shreg[0] : shreg[DATA_W-1];
        shreg   <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
        bidx    <= (bidx == BIDX_W'(DATA_W - 1)) ? '0 : bidx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rcvbuf_stream.sv
// Directed bench for rcvbuf_stream with DATA_W=8, DEPTH=4, THRESH=2.
// Two instances share all stimulus: one LSB-first, one MSB-first.
module tb_rcvbuf_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       newdata = 1'b0;
  logic [7:0] rbr = 8'h00;
  logic       bit_tick = 1'b0;
  logic       flush = 1'b0;

  logic       databit_l, streaming_l, full_l, overflow_l, done_l;
  logic [2:0] level_l;
  logic       databit_m, streaming_m, full_m, overflow_m, done_m;
  logic [2:0] level_m;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rcvbuf_stream #(.DATA_W(8), .DEPTH(4), .THRESH(2), .LSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_lsb (
    .rcvbuf_clk(clk), .rst(rst), .newdata(newdata), .rbr(rbr), .bit_tick(bit_tick),
    .flush(flush), .databit(databit_l), .streaming(streaming_l), .level(level_l),
    .full(full_l), .overflow(overflow_l), .done(done_l)
  );

  rcvbuf_stream #(.DATA_W(8), .DEPTH(4), .THRESH(2), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_msb (
    .rcvbuf_clk(clk), .rst(rst), .newdata(newdata), .rbr(rbr), .bit_tick(bit_tick),
    .flush(flush), .databit(databit_m), .streaming(streaming_m), .level(level_m),
    .full(full_m), .overflow(overflow_m), .done(done_m)
  );

  // Advance one clock; outputs are read 1 ns after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic write_word(input logic [7:0] w);
    rbr = w;
    newdata = 1'b1;
    cycle();
    newdata = 1'b0;
  endtask

  task automatic tick();
    bit_tick = 1'b1;
    cycle();
    bit_tick = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  // Reset with every strobe asserted: reset must win.
  task automatic test_reset();
    rst = 1'b1; newdata = 1'b1; rbr = 8'hFF; bit_tick = 1'b1; flush = 1'b1;
    cycle();
    rst = 1'b0; newdata = 1'b0; bit_tick = 1'b0; flush = 1'b0;
    total++;
    if (level_l !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level_l); end
    total++;
    if ({databit_l, streaming_l, full_l, overflow_l, done_l} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {databit_l, streaming_l, full_l, overflow_l, done_l});
    end
  endtask

  // Two words, 16 ticks with idle gaps, then the terminating tick.
  task automatic test_basic();
    logic [15:0] seq;
    seq = 16'b1010_0101_0011_1100;
    do_reset();
    write_word(8'hA5);
    total++;
    if (streaming_l !== 1'b0 || level_l !== 3'd1) begin
      bad++; $display("FAIL basic_first_write streaming=%b level=%0d exp streaming=0 level=1", streaming_l, level_l);
    end
    write_word(8'h3C);
    total++;
    if (streaming_l !== 1'b1 || level_l !== 3'd2) begin
      bad++; $display("FAIL basic_stream_start streaming=%b level=%0d exp streaming=1 level=2", streaming_l, level_l);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      total++;
      if (databit_l !== seq[15-i]) begin bad++; $display("FAIL basic_bit%0d got=%b exp=%b", i, databit_l, seq[15-i]); end
      cycle();
      total++;
      if (databit_l !== seq[15-i]) begin bad++; $display("FAIL basic_hold%0d got=%b exp=%b", i, databit_l, seq[15-i]); end
      if (i == 0) begin
        total++;
        if (level_l !== 3'd1) begin bad++; $display("FAIL basic_level_after_pop got=%0d exp=1", level_l); end
      end
    end
    total++;
    if (streaming_l !== 1'b1 || done_l !== 1'b0) begin
      bad++; $display("FAIL basic_before_end streaming=%b done=%b exp streaming=1 done=0", streaming_l, done_l);
    end
    tick();
    total++;
    if ({done_l, databit_l, streaming_l} !== 3'b100) begin
      bad++; $display("FAIL basic_end done,databit,streaming got=%b exp=100", {done_l, databit_l, streaming_l});
    end
    cycle();
    total++;
    if (done_l !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b exp=0", done_l); end
  endtask

  // Five writes into a four-word buffer; the fifth must never be sent.
  task automatic test_overflow();
    logic [7:0] w;
    do_reset();
    for (int i = 1; i <= 5; i++) write_word(8'(i));
    total++;
    if ({level_l, full_l, overflow_l} !== {3'd4, 1'b1, 1'b1}) begin
      bad++; $display("FAIL ovf_state level=%0d full=%b overflow=%b exp 4 1 1", level_l, full_l, overflow_l);
    end
    for (int k = 1; k <= 4; k++) begin
      w = 8'h00;
      for (int b = 0; b < 8; b++) begin
        tick();
        w[b] = databit_l;
      end
      total++;
      if (w !== 8'(k)) begin bad++; $display("FAIL ovf_word%0d got=%h exp=%h", k, w, 8'(k)); end
    end
    tick();
    total++;
    if ({done_l, streaming_l, level_l} !== {1'b1, 1'b0, 3'd0}) begin
      bad++; $display("FAIL ovf_end done=%b streaming=%b level=%0d exp 1 0 0", done_l, streaming_l, level_l);
    end
    total++;
    if (overflow_l !== 1'b1 || full_l !== 1'b0) begin
      bad++; $display("FAIL ovf_sticky overflow=%b full=%b exp 1 0", overflow_l, full_l);
    end
  endtask

  // Flush below threshold, and flush on an empty buffer.
  task automatic test_flush();
    logic [7:0] seq;
    seq = 8'b1000_0001;
    do_reset();
    pulse_flush();
    total++;
    if (streaming_l !== 1'b0) begin bad++; $display("FAIL flush_empty streaming=%b exp=0", streaming_l); end
    write_word(8'h81);
    total++;
    if (streaming_l !== 1'b0) begin bad++; $display("FAIL flush_below_thresh streaming=%b exp=0", streaming_l); end
    pulse_flush();
    total++;
    if (streaming_l !== 1'b1 || level_l !== 3'd1) begin
      bad++; $display("FAIL flush_start streaming=%b level=%0d exp 1 1", streaming_l, level_l);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (databit_l !== seq[7-i]) begin bad++; $display("FAIL flush_bit%0d got=%b exp=%b", i, databit_l, seq[7-i]); end
    end
    tick();
    total++;
    if (done_l !== 1'b1 || streaming_l !== 1'b0) begin
      bad++; $display("FAIL flush_end done=%b streaming=%b exp 1 0", done_l, streaming_l);
    end
    pulse_flush();
    total++;
    if (streaming_l !== 1'b0) begin bad++; $display("FAIL flush_after_drain streaming=%b exp=0", streaming_l); end
  endtask

  // Write and pop in the same cycle at a word boundary, then drain all words.
  task automatic test_same_cycle();
    logic [7:0] w;
    logic [7:0] exp_w [4];
    exp_w = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    write_word(8'h11);
    write_word(8'h22);
    write_word(8'h33);
    rbr = 8'h44; newdata = 1'b1; bit_tick = 1'b1;
    cycle();
    newdata = 1'b0; bit_tick = 1'b0;
    total++;
    if ({level_l, overflow_l, databit_l} !== {3'd3, 1'b0, 1'b1}) begin
      bad++; $display("FAIL same_cycle level=%0d overflow=%b databit=%b exp 3 0 1", level_l, overflow_l, databit_l);
    end
    for (int k = 0; k < 4; k++) begin
      w = 8'h00;
      for (int b = 0; b < 8; b++) begin
        if (k != 0 || b != 0) tick();
        w[b] = databit_l;
      end
      total++;
      if (w !== exp_w[k]) begin bad++; $display("FAIL same_cycle_word%0d got=%h exp=%h", k, w, exp_w[k]); end
    end
    tick();
    total++;
    if (done_l !== 1'b1) begin bad++; $display("FAIL same_cycle_end done=%b exp=1", done_l); end
  endtask

  // Reset three bits into a word; later ticks must stay idle.
  task automatic test_reset_mid();
    do_reset();
    write_word(8'hA5);
    write_word(8'h3C);
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (databit_l !== 1'b1) begin bad++; $display("FAIL mid_pre_reset databit=%b exp=1", databit_l); end
    rst = 1'b1; bit_tick = 1'b1;
    cycle();
    rst = 1'b0; bit_tick = 1'b0;
    total++;
    if ({level_l, databit_l, streaming_l} !== {3'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL mid_reset level=%0d databit=%b streaming=%b exp 0 0 0", level_l, databit_l, streaming_l);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (databit_l !== 1'b0 || streaming_l !== 1'b0) begin
        bad++; $display("FAIL mid_after_tick%0d databit=%b streaming=%b exp 0 0", i, databit_l, streaming_l);
      end
    end
  endtask

  // MSB-first rerun of the two-word sequence, then an asymmetric word on both.
  task automatic test_bit_order();
    logic [15:0] seq;
    logic [7:0]  w;
    seq = 16'b1010_0101_0011_1100;
    do_reset();
    write_word(8'hA5);
    write_word(8'h3C);
    for (int i = 0; i < 16; i++) begin
      tick();
      total++;
      if (databit_m !== seq[15-i]) begin bad++; $display("FAIL msb_bit%0d got=%b exp=%b", i, databit_m, seq[15-i]); end
    end
    tick();
    total++;
    if (done_m !== 1'b1 || databit_m !== 1'b0) begin
      bad++; $display("FAIL msb_end done=%b databit=%b exp 1 0", done_m, databit_m);
    end
    w = 8'h12;
    do_reset();
    write_word(w);
    pulse_flush();
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (databit_l !== w[i]) begin bad++; $display("FAIL order_lsb_bit%0d got=%b exp=%b", i, databit_l, w[i]); end
      total++;
      if (databit_m !== w[7-i]) begin bad++; $display("FAIL order_msb_bit%0d got=%b exp=%b", i, databit_m, w[7-i]); end
    end
  endtask

  initial begin
    cycle();
    test_reset();
    test_basic();
    test_overflow();
    test_flush();
    test_same_cycle();
    test_reset_mid();
    test_bit_order();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
